// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and helpers for the parametrised FIFO family
package fifo_pkg;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 16;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return r;
    endfunction

    localparam int DEF_PTR_W = clog2(DEF_DEPTH);
    localparam int DEF_CNT_W = DEF_PTR_W + 1;
endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: DEPTH x WIDTH storage, synchronous write, asynchronous read
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    // contents are intentionally not reset; occupancy tracking decides validity
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with thresholds, flush, sticky errors, optional FWFT
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_THRESH = 12,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    flush,
    input  logic                    wr_en,
    input  logic [WIDTH-1:0]        din,
    input  logic                    rd_en,
    output logic [WIDTH-1:0]        dout,
    output logic                    dout_valid,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [clog2(DEPTH):0]   count,
    output logic                    overflow,
    output logic                    underflow,
    input  logic                    clr_err
);
    localparam int PW = clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [WIDTH-1:0] ram_q, dout_q;
    logic             dout_valid_q;
    logic             push_ok, pop_ok;

    assign full         = count == CW'(DEPTH);
    assign empty        = count == '0;
    assign almost_full  = count >= CW'(AF_THRESH);
    assign almost_empty = count <= CW'(AE_THRESH);

    // both requests are judged against the pre-edge state, so a pop never frees room for a same-cycle push
    assign push_ok = en & wr_en & ~full & ~flush;
    assign pop_ok  = en & rd_en & ~empty & ~flush;

    assign dout       = FWFT != 0 ? ram_q : dout_q;
    assign dout_valid = FWFT != 0 ? ~empty : dout_valid_q;

    fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(PW)) u_ram (
        .clk   (clk),
        .we    (push_ok),
        .waddr (wr_ptr),
        .wdata (din),
        .raddr (rd_ptr),
        .rdata (ram_q)
    );

    // pointers wrap modulo DEPTH; count nets out simultaneous push and pop
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= flush ? '0 : wr_ptr + PW'(push_ok);
            rd_ptr <= flush ? '0 : rd_ptr + PW'(pop_ok);
            count  <= flush ? '0 : count + CW'(push_ok) - CW'(pop_ok);
        end

    // registered read stage: dout holds the last popped word, valid pulses for one cycle
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            dout_valid_q <= pop_ok;
            if (pop_ok) dout_q <= ram_q;
        end

    // sticky error capture; a new error in the same cycle as clr_err keeps the flag set
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (en & wr_en & full & ~flush) | (overflow & ~clr_err);
            underflow <= (en & rd_en & empty & ~flush) | (underflow & ~clr_err);
        end
endmodule
